line_fill_ctrl: RTL and testbench

- Fetch/sequencing stage directly upstream of the 4-row x 128-bit line buffer.
- Reads 32-bit image words from a synchronous word RAM and writes them into the buffer (write enable, row/byte address).
- Steps a 4x4-byte window across each 16-byte row group and hands each window to the downstream convolution engine with a valid/ready handshake.
- Between row groups it pulses shift_up and refills row 3, sliding the band down the image by one row.

---
 rtl/line_fill_ctrl.sv | 165 ++++++++++++++++
 tb/tb_line_fill_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_ctrl
// Description : Fetch/sequencing stage for the 4-row x 128-bit line buffer.
//               Fills the buffer from a synchronous word RAM, steps a 4x4
//               byte window across each row group with a valid/ready
//               handshake, then shifts the band down one row and refills
//               row 3 until the bottom of the image is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module line_fill_ctrl #(
    parameter int IMG_ROWS      = 16,
    parameter int WORDS_PER_ROW = 4,
    parameter int ADDR_W        = 16,
    parameter int BASE          = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       buf_data,
    output logic              buf_we,
    output logic              buf_shift_up,
    output logic [8:0]        buf_addr,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [7:0]        win_row,
    output logic [3:0]        win_col,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_wpr      = ADDR_W'(WORDS_PER_ROW);
    localparam logic [7:0]        c_last_row = 8'(IMG_ROWS - 4);
    localparam logic [3:0]        c_last_col = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WIN   = 3'd2,
        S_SHIFT = 3'd3,
        S_LOAD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [4:0]        r_cnt;        // cycle index inside FILL / LOAD
    logic [ADDR_W-1:0] w_load_addr;  // first word of the row entering row 3

    // The buffer performs its own byte swap, so data passes straight through.
    assign buf_data = mem_rdata;

    // Evaluated in SHIFT, before win_row advances: row (win_row+1)+3.
    assign w_load_addr = c_base + (ADDR_W'(win_row) + ADDR_W'(4)) * c_wpr;

    // Sequencer: every output is registered and set one cycle ahead; each
    // buffer write trails its RAM read by one cycle to match RAM latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            buf_we       <= 1'b0;
            buf_shift_up <= 1'b0;
            buf_addr     <= '0;
            win_valid    <= 1'b0;
            win_row      <= '0;
            win_col      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mem_rd       <= 1'b0;
            buf_we       <= 1'b0;
            buf_shift_up <= 1'b0;
            done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_FILL;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= c_base;
                        r_cnt    <= '0;
                        win_row  <= '0;
                        win_col  <= '0;
                        buf_addr <= '0;
                    end
                end
                S_FILL: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt < 5'd15) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + c_addr_one;
                    end
                    if (!r_cnt[4]) begin
                        // Word r_cnt lands at row r_cnt[3:2], byte r_cnt[1:0]*4.
                        buf_we   <= 1'b1;
                        buf_addr <= {3'b000, r_cnt[3:0], 2'b00};
                    end else begin
                        r_state   <= S_WIN;
                        win_valid <= 1'b1;
                        win_col   <= '0;
                        buf_addr  <= '0;
                    end
                end
                S_WIN: begin
                    if (win_ready) begin
                        if (win_col == c_last_col) begin
                            win_valid <= 1'b0;
                            if (win_row == c_last_row) begin
                                r_state <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                r_state      <= S_SHIFT;
                                buf_shift_up <= 1'b1;
                            end
                        end else begin
                            win_col  <= win_col + 4'd1;
                            buf_addr <= {5'b00000, win_col + 4'd1};
                        end
                    end
                end
                S_SHIFT: begin
                    // Buffer shifts on this edge, so the band's top row moves too.
                    r_state  <= S_LOAD;
                    win_row  <= win_row + 8'd1;
                    win_col  <= '0;
                    r_cnt    <= '0;
                    mem_rd   <= 1'b1;
                    mem_addr <= w_load_addr;
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt < 5'd3) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + c_addr_one;
                    end
                    if (r_cnt < 5'd4) begin
                        buf_we   <= 1'b1;
                        buf_addr <= {5'b00011, r_cnt[1:0], 2'b00};
                    end else begin
                        r_state   <= S_WIN;
                        win_valid <= 1'b1;
                        win_col   <= '0;
                        buf_addr  <= '0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_fill_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_fill_ctrl
// Description : Self-checking bench for line_fill_ctrl. A transaction-level
//               model lists the expected RAM reads, buffer writes and window
//               sequence per frame; a RAM model answers reads one cycle late.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_ctrl;

    localparam int IMG_ROWS = 6;
    localparam int ADDR_W   = 16;
    localparam int BASE     = 'hFFF4;   // frame straddles the address wrap
    localparam int NWIN     = (IMG_ROWS - 3) * 13;
    localparam int NSHIFT   = IMG_ROWS - 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              win_ready = 1'b0;
    logic [31:0]       mem_rdata = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       buf_data;
    logic              buf_we;
    logic              buf_shift_up;
    logic [8:0]        buf_addr;
    logic              win_valid;
    logic [7:0]        win_row;
    logic [3:0]        win_col;
    logic              busy;
    logic              done;

    line_fill_ctrl #(
        .IMG_ROWS(IMG_ROWS), .WORDS_PER_ROW(4), .ADDR_W(ADDR_W), .BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .buf_data(buf_data), .buf_we(buf_we), .buf_shift_up(buf_shift_up),
        .buf_addr(buf_addr), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected transaction lists for the current frame.
    logic [15:0] q_rd[$];
    logic [8:0]  q_wa[$];
    logic [31:0] q_wd[$];
    logic [11:0] q_win[$];

    logic        prev_rd = 1'b0;
    logic [15:0] prev_addr = '0;
    logic        prev_acc = 1'b0;
    logic [3:0]  prev_acc_col = '0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_stall_addr = '0;
    int          n_win, n_shift, n_done, n_rd, stall_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return {a ^ 16'hC3A5, ~a};
    endfunction

    task automatic build_model();
        logic [15:0] a;
        q_rd.delete(); q_wa.delete(); q_wd.delete(); q_win.delete();
        for (int w = 0; w < 16; w++) begin
            a = 16'(BASE + w);
            q_rd.push_back(a); q_wa.push_back(9'(w * 4)); q_wd.push_back(ram_word(a));
        end
        for (int r = 1; r <= NSHIFT; r++) begin
            for (int k = 0; k < 4; k++) begin
                a = 16'(BASE + (r + 3) * 4 + k);
                q_rd.push_back(a); q_wa.push_back(9'(48 + 4 * k)); q_wd.push_back(ram_word(a));
            end
        end
        for (int r = 0; r <= IMG_ROWS - 4; r++)
            for (int c = 0; c < 13; c++)
                q_win.push_back({8'(r), 4'(c)});
    endtask

    // One clock: RAM answer, output checks, then drive win_ready/start.
    task automatic step(input int mode);
        logic        r;
        logic [11:0] e;
        @(posedge clk); #1;
        mem_rdata = prev_rd ? ram_word(prev_addr) : $urandom;
        #1;
        chk("one_hot_excl", 32'($countones({buf_we, buf_shift_up, win_valid}) <= 1), 1);
        if (prev_stall) begin
            chk("stall_valid_hold", win_valid, 1);
            chk("stall_addr_hold", buf_addr, prev_stall_addr);
        end
        if (prev_acc) begin
            if (prev_acc_col == 4'd12) chk("after_last_col_valid", win_valid, 0);
            else begin
                chk("next_win_valid", win_valid, 1);
                chk("next_win_col", win_col, prev_acc_col + 4'd1);
            end
        end
        if (mem_rd) begin
            chk("rd_expected", q_rd.size() > 0, 1);
            if (q_rd.size() > 0) chk("rd_addr", mem_addr, q_rd.pop_front());
            n_rd++;
        end
        if (buf_we) begin
            chk("we_lags_rd", prev_rd, 1);
            chk("we_expected", q_wa.size() > 0, 1);
            if (q_wa.size() > 0) begin
                chk("we_addr", buf_addr, q_wa.pop_front());
                chk("we_data", buf_data, q_wd.pop_front());
            end
        end
        if (buf_shift_up) begin
            chk("shift_after_wins", n_win, 13 * (n_shift + 1));
            chk("shift_after_reads", n_rd, 16 + 4 * n_shift);
            chk("shift_row", win_row, n_shift);
            n_shift++;
        end
        if (done) n_done++;
        prev_rd   = mem_rd;
        prev_addr = mem_addr;

        r = 1'b1;
        if (mode == 1 && win_valid && win_col == 4'd7 && stall_left > 0) begin
            r = 1'b0;
            stall_left--;
        end else if (mode == 2) begin
            r = ($urandom_range(0, 3) != 0);
        end
        start     = (mode == 1) && win_valid && (win_col == 4'd3) && (win_row == 8'd0);
        win_ready = r;
        prev_stall      = win_valid && !r;
        prev_stall_addr = buf_addr;
        prev_acc        = win_valid && r;
        prev_acc_col    = win_col;
        if (win_valid && r) begin
            n_win++;
            chk("win_expected", q_win.size() > 0, 1);
            if (q_win.size() > 0) begin
                e = q_win.pop_front();
                chk("win_row", win_row, e[11:4]);
                chk("win_col", win_col, e[3:0]);
                chk("win_buf_addr", buf_addr, {5'b00000, e[3:0]});
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_buf_we", buf_we, 0);
        chk("rst_shift_up", buf_shift_up, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_buf_addr", buf_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
    endtask

    task automatic run_frame(input int mode, input bit abort_in_load);
        build_model();
        n_win = 0; n_shift = 0; n_done = 0; n_rd = 0; stall_left = 5;
        start = 1'b1;
        step(mode);
        chk("start_first_rd", mem_rd, 1);
        chk("start_busy", busy, 1);
        for (int cyc = 0; cyc < 3000 && n_done == 0; cyc++) begin
            step(mode);
            if (abort_in_load && n_rd == 18) return;
            chk("busy_in_frame", busy, 1);
        end
        if (abort_in_load) begin
            chk("abort_point_reached", n_rd, 18);
            return;
        end
        chk("frame_done_seen", n_done, 1);
        step(mode);
        chk("busy_after_done", busy, 0);
        chk("done_pulse_width", n_done, 1);
        chk("win_count", n_win, NWIN);
        chk("shift_count", n_shift, NSHIFT);
        chk("reads_left", q_rd.size(), 0);
        chk("writes_left", q_wa.size(), 0);
        chk("wins_left", q_win.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step(0);
        check_reset_vals();
        rst = 1'b0;
        step(0);
        chk("idle_busy", busy, 0);
        chk("idle_mem_rd", mem_rd, 0);

        run_frame(0, 1'b0);   // ready always high
        run_frame(1, 1'b0);   // 5-cycle stall at col 7, start poked in WIN
        run_frame(0, 1'b1);   // abandoned after two LOAD reads

        rst = 1'b1;
        step(0);
        check_reset_vals();
        rst = 1'b0;
        q_rd.delete(); q_wa.delete(); q_wd.delete(); q_win.delete();
        repeat (5) begin
            step(0);
            chk("post_rst_no_we", buf_we, 0);
            chk("post_rst_idle", busy, 0);
        end

        run_frame(2, 1'b0);   // random backpressure after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
